// File: rtl/obf_pkg.sv
// obf_pkg: constants and state type shared by the key serializer and the locked FSM
package obf_pkg;
    typedef enum logic [1:0] {IDLE, KEY, DATA} state_t;
    localparam int OBF_KEY_W = 5;
    localparam logic [OBF_KEY_W-1:0] OBF_KEY = 5'b11110;
endpackage

// File: rtl/piso_shift.sv
// piso_shift: parallel-in/serial-out register, MSB first, refilled from the low end with FILL
module piso_shift #(
    parameter int   W    = 8,
    parameter logic FILL = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] sh_q;
    always_ff @(posedge clk) begin
        if (!rst_n) sh_q <= {W{FILL}};
        else if (load) sh_q <= din;
        else if (shift) sh_q <= {sh_q[W-2:0], FILL};
    end
    assign msb = sh_q[W-1];
endmodule

// File: rtl/obf_key_serializer.sv
// obf_key_serializer: shifts the unlock key then data words onto one serial line feeding the locked FSM
module obf_key_serializer
    import obf_pkg::*;
#(
    parameter int   KEY_W    = OBF_KEY_W,
    parameter int   DATA_W   = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              x_out,
    output logic              x_valid,
    output logic              busy,
    output logic              key_done
);
    localparam int CW = $clog2(KEY_W > DATA_W ? KEY_W : DATA_W);
    state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic x_valid_q, x_valid_d, key_done_q, key_done_d;
    logic load, shift;
    logic [DATA_W-1:0] load_val;
    // The shifter refills with IDLE_BIT, so x_out falls to IDLE_BIT by itself once a word drains
    piso_shift #(.W(DATA_W), .FILL(IDLE_BIT)) u_piso (
        .clk(clk), .rst_n(rst_n), .load(load), .shift(shift), .din(load_val), .msb(x_out)
    );
    assign data_ready = (state_q == DATA) && (!x_valid_q || cnt_q == '0);
    assign x_valid    = x_valid_q;
    assign busy       = state_q != IDLE;
    assign key_done   = key_done_q;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        x_valid_d  = x_valid_q;
        key_done_d = key_done_q;
        load       = 1'b0;
        shift      = 1'b0;
        load_val   = {DATA_W{IDLE_BIT}};
        if (abort) begin
            state_d   = IDLE;
            cnt_d     = '0;
            x_valid_d = 1'b0;
            load      = 1'b1;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    state_d    = KEY;
                    cnt_d      = CW'(KEY_W - 1);
                    key_done_d = 1'b0;
                    x_valid_d  = 1'b1;
                    load       = 1'b1;
                    load_val[DATA_W-1 -: KEY_W] = key_in;
                end
                KEY: begin
                    shift = 1'b1;
                    if (cnt_q == '0) begin
                        state_d    = DATA;
                        key_done_d = 1'b1;
                        x_valid_d  = 1'b0;
                    end else cnt_d = cnt_q - CW'(1);
                end
                DATA: if (data_valid && data_ready) begin
                    load      = 1'b1;
                    load_val  = data_in;
                    cnt_d     = CW'(DATA_W - 1);
                    x_valid_d = 1'b1;
                end else if (x_valid_q) begin
                    shift = 1'b1;
                    if (cnt_q == '0) x_valid_d = 1'b0;
                    else cnt_d = cnt_q - CW'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            x_valid_q  <= 1'b0;
            key_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            x_valid_q  <= x_valid_d;
            key_done_q <= key_done_d;
        end
    end
endmodule

// File: tb/tb_obf_key_serializer.sv
// tb_obf_key_serializer: directed stimulus with a bit-stream scoreboard checked by an independent monitor
module tb_obf_key_serializer;
    logic clk = 1'b0;
    logic rst_n, start, abort, data_valid;
    logic [4:0] key_in;
    logic [7:0] data_in;
    logic data_ready, x_out, x_valid, busy, key_done;
    logic exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    obf_key_serializer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .x_out(x_out), .x_valid(x_valid), .busy(busy), .key_done(key_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_bits(input logic [7:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every valid bit must be the next scoreboard entry; idle line must sit at 0
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (x_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stream: got unexpected bit %b, no bit expected at %0t", x_out, $time);
                end else begin
                    logic e;
                    e = exp_q.pop_front();
                    n_cmp--;
                    check("stream", x_out, e);
                end
            end else check("idle_bit", x_out, 1'b0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; data_valid = 1'b0;
        key_in = 5'b0; data_in = 8'h0;
        tick(); tick();
        check("rst_x_out", x_out, 1'b0);
        check("rst_x_valid", x_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_key_done", key_done, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        // key 11110: bits in cycles 1-5, key_done from cycle 6
        start = 1'b1; key_in = 5'b11110;
        push_bits({3'b0, 5'b11110}, 5);
        tick();
        start = 1'b0;
        check("key_busy", busy, 1'b1);
        check("key_done_low", key_done, 1'b0);
        check("key_valid", x_valid, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        check("key_done_c5", key_done, 1'b0);
        check("key_ready_c5", data_ready, 1'b0);
        tick();
        check("key_done_c6", key_done, 1'b1);
        check("gap_valid_c6", x_valid, 1'b0);
        check("ready_c6", data_ready, 1'b1);
        // A5 accepted in cycle 6, bits in 7-14, ready only in 14
        data_in = 8'hA5; data_valid = 1'b1;
        push_bits(8'hA5, 8);
        tick();
        data_valid = 1'b0;
        for (int c = 7; c <= 13; c++) begin
            check("a5_ready_busy", data_ready, 1'b0);
            tick();
        end
        check("a5_ready_last", data_ready, 1'b1);
        tick();
        check("a5_done_valid", x_valid, 1'b0);
        // FF then 00 back to back, 16 contiguous valid bits
        data_in = 8'hFF; data_valid = 1'b1;
        push_bits(8'hFF, 8);
        push_bits(8'h00, 8);
        tick();
        data_in = 8'h00;
        for (int k = 0; k < 16; k++) begin
            check("b2b_contig", x_valid, 1'b1);
            if (k == 7) check("b2b_ready", data_ready, 1'b1);
            tick();
            if (k == 7) data_valid = 1'b0;
        end
        check("b2b_end_valid", x_valid, 1'b0);
        // start during DATA is ignored, then reset mid-word
        data_in = 8'h3C; data_valid = 1'b1; start = 1'b1; key_in = 5'b11110;
        push_bits(8'h3C, 8);
        tick();
        data_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check("start_in_data_busy", busy, 1'b1);
        check("start_in_data_key_done", key_done, 1'b1);
        start = 1'b0;
        rst_n = 1'b0;
        tick();
        exp_q.delete();
        check("midrst_x_out", x_out, 1'b0);
        check("midrst_x_valid", x_valid, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_key_done", key_done, 1'b0);
        check("midrst_ready", data_ready, 1'b0);
        rst_n = 1'b1;
        tick();
        // abort in cycle 3 of the key
        start = 1'b1; key_in = 5'b11110;
        push_bits(8'b111, 3);
        tick();
        start = 1'b0;
        tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_valid", x_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_key_done", key_done, 1'b0);
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", busy, 1'b0);
        start = 1'b1;
        push_bits({3'b0, 5'b11110}, 5);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("replay_key_done", key_done, 1'b1);
        // wrong key goes out verbatim
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_keeps_key_done", key_done, 1'b1);
        start = 1'b1; key_in = 5'b11100;
        push_bits({3'b0, 5'b11100}, 5);
        tick();
        start = 1'b0;
        check("wrong_key_clears_done", key_done, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        check("wrong_key_done", key_done, 1'b1);
        check("wrong_key_end_valid", x_valid, 1'b0);
        tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d bits outstanding expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
